// File: rtl/pipe_share_sched.sv
`default_nettype none
// ============================================================================
// Module      : pipe_share_sched
// Description : Round-robin scheduler sharing one stallable fixed-latency
//               pipeline among NREQ requesters, with valid/ready result port.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_share_sched #(
    parameter int DW   = 8,
    parameter int NREQ = 4,
    parameter int LAT  = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DW-1:0]       req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     pipe_en,
    output logic [DW-1:0]            pipe_in,
    input  logic [DW-1:0]            pipe_out,
    output logic                     out_valid,
    output logic [DW-1:0]            out_data,
    output logic [IDW-1:0]           out_id,
    input  logic                     out_ready,
    output logic [$clog2(LAT+1)-1:0] inflight
);

    localparam int             c_cw   = $clog2(LAT + 1);
    localparam logic [IDW:0]   c_nreq = (IDW + 1)'(NREQ);
    localparam logic [IDW-1:0] c_last = IDW'(NREQ - 1);
    localparam logic [NREQ-1:0] c_one = NREQ'(1);

    logic [LAT-1:0]  r_vld;
    logic [IDW-1:0]  r_id [LAT];
    logic [IDW-1:0]  r_ptr;
    logic [c_cw-1:0] r_inflight;

    logic [IDW-1:0]  w_gnt;
    logic [IDW:0]    w_idx;
    logic            w_found;
    logic            w_accept;
    logic            w_xfer;

    // Priority search starting at the RR pointer, wrapping modulo NREQ
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = {1'b0, r_ptr} + (IDW + 1)'(i);
            if (w_idx >= c_nreq) begin
                w_idx = w_idx - c_nreq;
            end
            if (!w_found && req_valid[w_idx[IDW-1:0]]) begin
                w_found = 1'b1;
                w_gnt   = w_idx[IDW-1:0];
            end
        end
    end

    assign out_valid = r_vld[LAT-1];
    assign out_id    = r_id[LAT-1];
    assign out_data  = pipe_out;
    assign inflight  = r_inflight;

    // A held result freezes every stage, including the external chain
    assign pipe_en   = ~(out_valid & ~out_ready);
    assign w_accept  = w_found & pipe_en;
    assign w_xfer    = out_valid & out_ready;
    assign req_ready = w_accept ? (c_one << w_gnt) : '0;
    assign pipe_in   = w_found ? req_data[int'(w_gnt)*DW +: DW] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld      <= '0;
            r_ptr      <= '0;
            r_inflight <= '0;
            for (int k = 0; k < LAT; k++) begin
                r_id[k] <= '0;
            end
        end else begin
            if (pipe_en) begin
                r_vld[0] <= w_accept;
                r_id[0]  <= w_gnt;
                for (int k = 1; k < LAT; k++) begin
                    r_vld[k] <= r_vld[k-1];
                    r_id[k]  <= r_id[k-1];
                end
            end
            if (w_accept) begin
                r_ptr <= (w_gnt == c_last) ? '0 : w_gnt + 1'b1;
            end
            case ({w_accept, w_xfer})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_share_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_share_sched
// Description : Bench for pipe_share_sched, LAT=4 and LAT=1 builds side by side
//               with behavioural models of the external chains.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_share_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic        out_ready;

    logic [3:0] rr0, rr1;
    logic       en0, en1, ov0, ov1;
    logic [7:0] pin0, pin1, pout0, pout1, od0, od1;
    logic [1:0] oid0, oid1;
    logic [2:0] inf0;
    logic [0:0] inf1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_share_sched #(.DW(8), .NREQ(4), .LAT(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(rr0), .pipe_en(en0), .pipe_in(pin0), .pipe_out(pout0),
        .out_valid(ov0), .out_data(od0), .out_id(oid0), .out_ready(out_ready),
        .inflight(inf0)
    );

    pipe_share_sched #(.DW(8), .NREQ(4), .LAT(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(rr1), .pipe_en(en1), .pipe_in(pin1), .pipe_out(pout1),
        .out_valid(ov1), .out_data(od1), .out_id(oid1), .out_ready(out_ready),
        .inflight(inf1)
    );

    // External enable-stallable delay chains, LEN 4 and LEN 1
    logic [7:0] ch0 [4];
    logic [7:0] ch1;
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) ch0[k] <= 8'h00;
            ch1 <= 8'h00;
        end else begin
            if (en0) begin
                ch0[0] <= pin0;
                for (int k = 1; k < 4; k++) ch0[k] <= ch0[k-1];
            end
            if (en1) ch1 <= pin1;
        end
    end
    assign pout0 = ch0[3];
    assign pout1 = ch1;

    task automatic do_reset();
        rst = 1'b1; req_valid = 4'b0000; req_data = 32'h0; out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++; if (ov0 !== 1'b0) begin n_errors++; $display("FAIL reset_ov0: got %b want 0", ov0); end
        n_checks++; if (inf0 !== 3'd0) begin n_errors++; $display("FAIL reset_inf0: got %0d want 0", inf0); end
        n_checks++; if (en0 !== 1'b1) begin n_errors++; $display("FAIL reset_en0: got %b want 1", en0); end
        n_checks++; if (oid0 !== 2'd0) begin n_errors++; $display("FAIL reset_id0: got %0d want 0", oid0); end
        n_checks++; if (rr0 !== 4'b0000) begin n_errors++; $display("FAIL reset_rr0_idle: got %b want 0000", rr0); end
        n_checks++; if (ov1 !== 1'b0 || inf1 !== 1'b0) begin n_errors++; $display("FAIL reset_lat1: got ov=%b inf=%0d want 0/0", ov1, inf1); end
        req_valid = 4'b1111; #1;
        n_checks++; if (rr0 !== 4'b0001) begin n_errors++; $display("FAIL reset_ptr0: got %b want 0001", rr0); end
        n_checks++; if (rr1 !== 4'b0001) begin n_errors++; $display("FAIL reset_ptr1: got %b want 0001", rr1); end
        req_valid = 4'b0000;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 4'b0001; req_data = 32'h0000_0011; #1;
        n_checks++; if (rr0 !== 4'b0001) begin n_errors++; $display("FAIL single_ready: got %b want 0001", rr0); end
        @(posedge clk); #1;
        req_valid = 4'b0000; req_data = 32'h0;
        for (int k = 1; k <= 5; k++) begin
            #1;
            n_checks++;
            if (ov0 !== (k == 4)) begin n_errors++; $display("FAIL single_valid c%0d: got %b want %b", k, ov0, (k == 4)); end
            if (k == 4) begin
                n_checks++; if (od0 !== 8'h11 || oid0 !== 2'd0) begin n_errors++; $display("FAIL single_result: got %h/%0d want 11/0", od0, oid0); end
            end
            n_checks++;
            if (inf0 !== ((k <= 4) ? 3'd1 : 3'd0)) begin n_errors++; $display("FAIL single_inflight c%0d: got %0d want %0d", k, inf0, (k <= 4) ? 1 : 0); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_all_rr();
        do_reset();
        req_valid = 4'b1111; req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        for (int k = 0; k < 16; k++) begin
            #1;
            n_checks++;
            if (rr0 !== 4'(1 << (k % 4))) begin n_errors++; $display("FAIL rr_grant c%0d: got %b want %b", k, rr0, 4'(1 << (k % 4))); end
            n_checks++;
            if (ov0 !== (k >= 4)) begin n_errors++; $display("FAIL rr_valid c%0d: got %b want %b", k, ov0, (k >= 4)); end
            if (k >= 4) begin
                n_checks++;
                if (oid0 !== 2'((k - 4) % 4) || od0 !== 8'(8'hA0 + (k - 4) % 4)) begin
                    n_errors++; $display("FAIL rr_result c%0d: got %h/%0d want %h/%0d", k, od0, oid0, 8'(8'hA0 + (k - 4) % 4), (k - 4) % 4);
                end
            end
            @(posedge clk); #1;
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_stall();
        do_reset();
        req_valid = 4'b1111; req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        for (int k = 0; k < 4; k++) begin @(posedge clk); #1; end
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (en0 !== 1'b0 || rr0 !== 4'b0000) begin n_errors++; $display("FAIL stall_frozen c%0d: got en=%b rr=%b want 0/0000", k, en0, rr0); end
            n_checks++; if (ov0 !== 1'b1 || od0 !== 8'hA0 || oid0 !== 2'd0) begin n_errors++; $display("FAIL stall_hold c%0d: got %b %h/%0d want 1 a0/0", k, ov0, od0, oid0); end
            n_checks++; if (inf0 !== 3'd4) begin n_errors++; $display("FAIL stall_inflight c%0d: got %0d want 4", k, inf0); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1; req_valid = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_checks++;
            if (k < 4 && (ov0 !== 1'b1 || oid0 !== 2'(k) || od0 !== 8'(8'hA0 + k) || inf0 !== 3'(4 - k))) begin
                n_errors++; $display("FAIL stall_drain c%0d: got %b %h/%0d inf=%0d want 1 %h/%0d inf=%0d", k, ov0, od0, oid0, inf0, 8'(8'hA0 + k), k, 4 - k);
            end else if (k == 4 && (ov0 !== 1'b0 || inf0 !== 3'd0)) begin
                n_errors++; $display("FAIL stall_empty: got ov=%b inf=%0d want 0/0", ov0, inf0);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sparse();
        do_reset();
        req_valid = 4'b1010; req_data = 32'h4433_2211; #1;
        n_checks++; if (rr0 !== 4'b0010) begin n_errors++; $display("FAIL sparse_first: got %b want 0010", rr0); end
        @(posedge clk); #2;
        n_checks++; if (rr0 !== 4'b1000) begin n_errors++; $display("FAIL sparse_second: got %b want 1000", rr0); end
        @(posedge clk); #1;
        req_valid = 4'b1111; #1;
        n_checks++; if (rr0 !== 4'b0001) begin n_errors++; $display("FAIL sparse_wrap: got %b want 0001", rr0); end
        req_valid = 4'b0000;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_valid = 4'b0010; req_data = 32'h005A_3322;
        for (int k = 0; k < 3; k++) begin @(posedge clk); #1; end
        rst = 1'b1; req_valid = 4'b0000;
        @(posedge clk); #1;
        rst = 1'b0; #1;
        n_checks++; if (ov0 !== 1'b0 || inf0 !== 3'd0) begin n_errors++; $display("FAIL midrst_flush: got ov=%b inf=%0d want 0/0", ov0, inf0); end
        req_valid = 4'b1111; #1;
        n_checks++; if (rr0 !== 4'b0001) begin n_errors++; $display("FAIL midrst_ptr: got %b want 0001", rr0); end
        req_valid = 4'b0100; #1;
        n_checks++; if (rr0 !== 4'b0100) begin n_errors++; $display("FAIL midrst_req2: got %b want 0100", rr0); end
        @(posedge clk); #1;
        req_valid = 4'b0000;
        for (int k = 1; k <= 4; k++) begin
            #1;
            n_checks++;
            if (ov0 !== (k == 4) || (k == 4 && (oid0 !== 2'd2 || od0 !== 8'h5A))) begin
                n_errors++; $display("FAIL midrst_out c%0d: got %b %h/%0d want %b 5a/2", k, ov0, od0, oid0, (k == 4));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lat1();
        logic       ev;
        logic [7:0] ed;
        logic       ee;
        do_reset();
        ev = 1'b0; ed = 8'h00;
        req_valid = 4'b0001;
        for (int k = 0; k < 12; k++) begin
            out_ready = (k % 2 == 0);
            req_data  = {24'h0, 8'(8'h40 + k)};
            #1;
            ee = !(ev && !out_ready);
            n_checks++; if (en1 !== ee || rr1 !== (ee ? 4'b0001 : 4'b0000)) begin n_errors++; $display("FAIL lat1_accept c%0d: got en=%b rr=%b want %b", k, en1, rr1, ee); end
            n_checks++; if (ov1 !== ev) begin n_errors++; $display("FAIL lat1_valid c%0d: got %b want %b", k, ov1, ev); end
            if (ev) begin
                n_checks++; if (od1 !== ed || oid1 !== 2'd0) begin n_errors++; $display("FAIL lat1_result c%0d: got %h/%0d want %h/0", k, od1, oid1, ed); end
            end
            if (ee) begin ev = 1'b1; ed = 8'(8'h40 + k); end
            @(posedge clk); #1;
        end
        req_valid = 4'b0000; out_ready = 1'b1;
    endtask

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
        int         stamp;
    } beat_t;

    // Reference: FIFO of accepted beats, each leaves after LAT advancing cycles
    task automatic test_random();
        beat_t      mq [2][$];
        int         mp [2];
        int         adv [2];
        int         lat_of [2];
        logic [3:0] rr_a [2];
        logic       en_a [2], ov_a [2];
        logic [7:0] od_a [2];
        logic [1:0] oid_a [2];
        int         inf_a [2];
        logic       ov_e, en_e, found;
        int         g, idx;
        logic [3:0] rdy_e;
        do_reset();
        lat_of[0] = 4; lat_of[1] = 1;
        for (int u = 0; u < 2; u++) begin mp[u] = 0; adv[u] = 0; mq[u].delete(); end
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst       = ($urandom_range(0, 79) == 0);
            req_valid = 4'($urandom);
            req_data  = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            rr_a[0] = rr0; en_a[0] = en0; ov_a[0] = ov0; od_a[0] = od0; oid_a[0] = oid0; inf_a[0] = int'(inf0);
            rr_a[1] = rr1; en_a[1] = en1; ov_a[1] = ov1; od_a[1] = od1; oid_a[1] = oid1; inf_a[1] = int'(inf1);
            for (int u = 0; u < 2; u++) begin
                ov_e  = (mq[u].size() > 0) && (adv[u] - mq[u][0].stamp == lat_of[u]);
                en_e  = !(ov_e && !out_ready);
                found = 1'b0; g = 0;
                for (int i = 0; i < 4; i++) begin
                    idx = (mp[u] + i) % 4;
                    if (!found && req_valid[idx]) begin found = 1'b1; g = idx; end
                end
                rdy_e = (en_e && found) ? 4'(1 << g) : 4'b0000;
                n_checks++; if (rr_a[u] !== rdy_e || en_a[u] !== en_e) begin n_errors++; $display("FAIL rand_grant u%0d c%0d: got rr=%b en=%b want %b/%b", u, cyc, rr_a[u], en_a[u], rdy_e, en_e); end
                n_checks++; if (ov_a[u] !== ov_e || inf_a[u] != mq[u].size()) begin n_errors++; $display("FAIL rand_state u%0d c%0d: got ov=%b inf=%0d want %b/%0d", u, cyc, ov_a[u], inf_a[u], ov_e, mq[u].size()); end
                if (ov_e) begin
                    n_checks++; if (od_a[u] !== mq[u][0].data || oid_a[u] !== mq[u][0].id) begin n_errors++; $display("FAIL rand_result u%0d c%0d: got %h/%0d want %h/%0d", u, cyc, od_a[u], oid_a[u], mq[u][0].data, mq[u][0].id); end
                end
                if (rst) begin
                    mq[u].delete(); mp[u] = 0;
                end else if (en_e) begin
                    if (ov_e) void'(mq[u].pop_front());
                    if (found) begin
                        mq[u].push_back('{id: 2'(g), data: req_data[g*8 +: 8], stamp: adv[u]});
                        mp[u] = (g + 1) % 4;
                    end
                    adv[u]++;
                end
            end
            @(posedge clk); #1;
        end
        rst = 1'b0; req_valid = 4'b0000; out_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1; req_valid = 4'b0000; req_data = 32'h0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_all_rr();
        test_stall();
        test_sparse();
        test_reset_mid();
        test_lat1();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_share_sched.md
Name: pipe_share_sched

Overview:
- Round-robin scheduler that shares one external fixed-latency, enable-stallable datapath pipeline (our DelayChain-style stage chain) among NREQ requesters.
- Grants one requester per advancing cycle and drives the pipeline's enable and input.
- Carries a valid bit and requester ID alongside the data, LAT stages deep.
- Presents the pipeline result downstream with valid/ready backpressure.

Parameters:
- DW, 8, data width of requests, pipeline input and pipeline output.
- NREQ, 4, number of requesters, legal range 2..16.
- LAT, 4, latency in stages of the external pipeline, legal range ≥1. Must equal the external chain's LEN.
- IDW, $clog2(NREQ), width of the requester ID (derived, do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_data  in  NREQ*DW  per-requester data; requester i occupies bits [i*DW +: DW].
- req_ready  out  NREQ  one-hot grant/accept; requester i's beat transfers when req_valid[i] & req_ready[i].
- pipe_en  out  1  enable to the external pipeline; all stages advance when high.
- pipe_in  out  DW  data into pipeline stage 0.
- pipe_out  in  DW  data from the pipeline's last stage.
- out_valid  out  1  result valid.
- out_data  out  DW  result data; equals pipe_out.
- out_id  out  IDW  requester ID of the result.
- out_ready  in  1  downstream accept.
- inflight  out  $clog2(LAT+1)  count of valid beats currently in the pipeline (0..LAT).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - Valid and ID shift registers are all 0, so out_valid=0, out_id=0 and inflight=0.
  - RR pointer is 0, so requester 0 has highest priority.
  - With the pipeline empty, pipe_en=1 in the first cycle after reset.
- Stall rule:
  - pipe_en = ~(out_valid & ~out_ready), combinational.
  - A stall freezes the whole pipeline: all LAT stages of vld/id plus the external chain.
  - Bubbles are not collapsed.
- Arbitration, combinational within the cycle:
  - Search req_valid starting at index ptr, wrapping modulo NREQ. The first set bit is the grant g.
  - req_ready = onehot(g) & {NREQ{pipe_en}}. req_ready is all 0 when pipe_en=0 or no request is present.
  - req_ready never depends on req_valid of a non-granted requester beyond the priority search.
- Issue:
  - pipe_in = req_data[g] when a grant occurs, else 0.
  - When pipe_en=1: vld[0] <= grant occurred; id[0] <= g; stages k = 1..LAT-1 shift from k-1.
- Pointer update: on an accepted beat, ptr <= (g+1) mod NREQ. Otherwise ptr holds.
- Output:
  - out_valid = vld[LAT-1]; out_id = id[LAT-1]; out_data = pipe_out.
  - Latency is exactly LAT advancing cycles from acceptance to out_valid.
  - Stalled cycles add to wall-clock latency only.
- Result handshake:
  - A result transfers when out_valid & out_ready.
  - While out_valid=1 & out_ready=0: out_valid, out_data and out_id hold stable, and no new beat is accepted.
- Inflight count:
  - +1 on accept, −1 on result transfer; both in the same cycle gives no change.
  - Must equal popcount(vld) at all times.
- LAT=1: single vld/id register. Same rules apply.
- Reset mid-operation: all in-flight beats are discarded, with no out_valid in the cycle after rst. ptr returns to 0. The external chain is reset by the same rst.
- Full throughput: with out_ready held high, one beat is accepted per cycle.
- Fairness: with all NREQ requesting continuously, each requester is granted once every NREQ accepted beats.

Test Plan:
- Setup for all scenarios: NREQ=4, LAT=4, DW=8, external chain LEN=4.
- Reset, then req_valid=4'b0001 with data 8'h11 for 1 cycle, out_ready=1:
  - req_ready=4'b0001 in that cycle.
  - out_valid=1, out_data=8'h11, out_id=0 exactly 4 cycles later.
  - inflight goes 1,1,1,1,0.
- All four requesting continuously with data 8'hA0+i, out_ready=1:
  - Grant order 0,1,2,3,0,1,…
  - Outputs appear in the same order, back to back, one per cycle after a 4-cycle fill.
- Pipeline full, out_ready=0 for 3 cycles:
  - pipe_en=0 and req_ready=0 during the stall; out_data and out_id held; inflight=4.
  - After out_ready rises, results drain in order with no loss or duplication.
- Sparse and competing requests:
  - req_valid=4'b1010 with ptr=0: grant goes to 1, ptr becomes 2.
  - Next cycle, same req_valid: grant goes to 3, ptr becomes 0.
- rst asserted for 1 cycle with 3 beats in flight:
  - Next cycle out_valid=0, inflight=0, ptr=0.
  - A subsequent request from requester 2 alone is granted immediately.
- LAT=1 build, continuous single requester, out_ready toggling 1,0,1,0:
  - Accepts only on cycles with pipe_en=1.
  - Each result appears 1 advancing cycle later with correct ID.
